// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two requesters.
// Captures the winning request, holds it on the ALU, and returns a tagged registered result.
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic [3:0]            req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [3:0]            req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    output logic                  req1_ready_o,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic                  rsp_zero_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  id_q, id_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  grant0, grant1;

    // Grants are masked while reset is asserted so no handshake is ever visible during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && reset) begin
            if (req0_valid_i && (!req1_valid_i || !prio_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid_i) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_d    = grant1 ? req1_op_i : req0_op_i;
                    a_d     = grant1 ? req1_a_i  : req0_a_i;
                    b_d     = grant1 ? req1_b_i  : req0_b_i;
                    id_d    = grant1;
                    cnt_d   = CNT_INIT;
                    prio_d  = ~grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d = alu_result_i;
                    zero_d   = alu_zero_i;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign alu_op_o     = op_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: model ALU, table-driven requests, scoreboarded responses.
// A second instance with a longer hold time checks the sampling point.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [3:0]  r0_op, r1_op, alu_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_result, rsp_result;
    logic        alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;

    logic        d3_valid, d3_ready, d3_nvalid, d3_nready;
    logic [3:0]  d3_op, d3_nop, d3_alu_op;
    logic [31:0] d3_a, d3_b, d3_na, d3_nb, d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_result;
    logic        d3_alu_zero, d3_rsp_valid, d3_rsp_ready, d3_rsp_id, d3_rsp_zero, d3_busy;
    logic [31:0] cyc = '0;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_result    = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero      = (alu_result == 32'd0);
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign d3_alu_result = d3_alu_a ^ cyc;
    assign d3_alu_zero   = (d3_alu_result == 32'd0);

    alu_share_arbiter #(.DATA_WIDTH(32), .EXEC_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(r0_valid), .req0_op_i(r0_op), .req0_a_i(r0_a), .req0_b_i(r0_b), .req0_ready_o(r0_ready),
        .req1_valid_i(r1_valid), .req1_op_i(r1_op), .req1_a_i(r1_a), .req1_b_i(r1_b), .req1_ready_o(r1_ready),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .busy_o(busy)
    );

    alu_share_arbiter #(.DATA_WIDTH(32), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid_i(d3_valid), .req0_op_i(d3_op), .req0_a_i(d3_a), .req0_b_i(d3_b), .req0_ready_o(d3_ready),
        .req1_valid_i(d3_nvalid), .req1_op_i(d3_nop), .req1_a_i(d3_na), .req1_b_i(d3_nb), .req1_ready_o(d3_nready),
        .alu_op_o(d3_alu_op), .alu_a_o(d3_alu_a), .alu_b_o(d3_alu_b),
        .alu_result_i(d3_alu_result), .alu_zero_i(d3_alu_zero),
        .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(d3_rsp_ready), .rsp_id_o(d3_rsp_id),
        .rsp_result_o(d3_rsp_result), .rsp_zero_o(d3_rsp_zero), .busy_o(d3_busy)
    );

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Response scoreboard: a handshake is certain once valid and ready are seen mid-cycle.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got id %0d result %0h, expected no response", rsp_id, rsp_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_zero", rsp_zero, e.zero);
            end
        end
    end

    task automatic set_req(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
        end else begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        end
    endtask

    task automatic wait_ready(input logic id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0_ready && r1_ready) chk("one_ready", 2, 1);
            if ((id ? r1_ready : r0_ready) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_ready");
    endtask

    task automatic wait_rsp_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_rsp_valid");
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("drain");
    endtask

    task automatic apply_vec(input vec_t v);
        bit ok;
        @(posedge clk); #1;
        set_req(v.id, v.op, v.a, v.b);
        wait_ready(v.id, ok);
        if (ok) q.push_back('{v.id, v.res, v.zero});
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        chk("exec_alu_op", alu_op, v.op);
        chk("exec_alu_a", alu_a, v.a);
        chk("exec_alu_b", alu_b, v.b);
        chk("exec_ready_low", v.id ? r1_ready : r0_ready, 0);
        chk("exec_rsp_valid_low", rsp_valid, 0);
        @(negedge clk);
        chk("latency_rsp_valid", rsp_valid, 1);
        drain();
    endtask

    initial begin
        bit ok;
        logic [31:0] c;

        vecs[0] = '{1'b0, 4'h0, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1'b1, 4'h1, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[2] = '{1'b0, 4'h2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
        vecs[3] = '{1'b1, 4'h3, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0};
        vecs[4] = '{1'b0, 4'h4, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0000_0000,  1'b1};
        vecs[5] = '{1'b1, 4'h0, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b1};
        vecs[6] = '{1'b0, 4'h1, 32'h0000_0000,  32'h0000_0001,  32'hFFFF_FFFF,  1'b0};
        vecs[7] = '{1'b1, 4'hF, 32'h8000_0000,  32'h1234_5678,  32'h8000_0000,  1'b0};

        reset = 1'b0;
        r0_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0;
        r1_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0;
        rsp_ready = 1'b1;
        d3_valid = 1'b0; d3_op = '0; d3_a = '0; d3_b = '0;
        d3_nvalid = 1'b0; d3_nop = '0; d3_na = '0; d3_nb = '0;
        d3_rsp_ready = 1'b1;

        // Reset state, with both requesters already asking
        repeat (2) @(posedge clk);
        #1;
        set_req(1'b0, 4'h2, 32'h0000_00FF, 32'h0000_000F);
        set_req(1'b1, 4'h0, 32'd1, 32'd1);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_ready0", r0_ready, 0);
        chk("rst_ready1", r1_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("first_grant_ready0", r0_ready, 1);
        chk("first_grant_ready1", r1_ready, 0);
        if (r0_ready) q.push_back('{1'b0, 32'h0000_000F, 1'b0});
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        // Single-requester table; prio ends at 0 after vecs[7]
        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // Both valid continuously: grants must alternate starting with req0
        @(posedge clk); #1;
        set_req(1'b0, 4'h0, 32'd1, 32'd2);
        set_req(1'b1, 4'h1, 32'd10, 32'd3);
        for (int g = 0; g < 6; g++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0_ready || r1_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                timeout("rr_grant");
            end else begin
                chk("rr_single_ready", r0_ready && r1_ready, 0);
                chk("rr_grant_id", r1_ready, g % 2);
                if (r1_ready) q.push_back('{1'b1, 32'd7, 1'b0});
                else          q.push_back('{1'b0, 32'd3, 1'b0});
            end
            @(posedge clk); #1;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        // Back-pressured response holds stable
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1'b1, 4'h1, 32'd9, 32'd9);
        wait_ready(1'b1, ok);
        if (ok) q.push_back('{1'b1, 32'd0, 1'b1});
        @(posedge clk); #1;
        r1_valid = 1'b0;
        wait_rsp_valid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_id", rsp_id, 1);
            chk("hold_rsp_result", rsp_result, 0);
            chk("hold_rsp_zero", rsp_zero, 1);
            chk("hold_busy", busy, 1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_back_idle", busy, 0);
        chk("hold_rsp_valid_fall", rsp_valid, 0);
        chk("hold_queue_empty", q.size(), 0);

        // Longer hold: result must be the ALU value just before the third edge after the handshake
        @(posedge clk); #1;
        d3_valid = 1'b1; d3_op = 4'h0; d3_a = 32'hA5A5_0000; d3_b = 32'd0;
        ok = 1'b0;
        c = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d3_ready) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
        end
        if (!ok) timeout("x3_ready");
        @(posedge clk); #1;
        d3_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("x3_rsp_valid_low", d3_rsp_valid, 0);
        end
        @(negedge clk);
        chk("x3_rsp_valid", d3_rsp_valid, 1);
        chk("x3_rsp_result", d3_rsp_result, 32'hA5A5_0000 ^ (c + 32'd3));
        chk("x3_rsp_zero", d3_rsp_zero, 0);
        chk("x3_rsp_id", d3_rsp_id, 0);
        @(negedge clk);
        chk("x3_idle", d3_busy, 0);

        // Reset during EXEC (req0 leaves prio pointing at req1)
        @(posedge clk); #1;
        set_req(1'b0, 4'h0, 32'd40, 32'd2);
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_alu_a", alu_a, 0);
        chk("rst_exec_alu_b", alu_b, 0);
        chk("rst_exec_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_exec_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        set_req(1'b0, 4'h0, 32'd3, 32'd4);
        set_req(1'b1, 4'h0, 32'd5, 32'd6);
        @(negedge clk);
        chk("rst_exec_prio_ready0", r0_ready, 1);
        chk("rst_exec_prio_ready1", r1_ready, 0);
        if (r0_ready) q.push_back('{1'b0, 32'd7, 1'b0});
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        // Reset during RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1'b1, 4'h3, 32'hF000_0000, 32'h0000_000F);
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        wait_rsp_valid();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_resp_rsp_valid", rsp_valid, 0);
        chk("rst_resp_rsp_id", rsp_id, 0);
        chk("rst_resp_rsp_result", rsp_result, 0);
        chk("rst_resp_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_resp_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        set_req(1'b0, 4'h4, 32'h0000_FFFF, 32'h0000_00FF);
        set_req(1'b1, 4'h0, 32'd1, 32'd1);
        @(negedge clk);
        chk("rst_resp_prio_ready0", r0_ready, 1);
        chk("rst_resp_prio_ready1", r1_ready, 0);
        if (r0_ready) q.push_back('{1'b0, 32'h0000_FF00, 1'b0});
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        drain();

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
